prio_encoder_q: RTL and testbench
=================================

// Module: prio_encoder_q
// PURPOSE
//   Parametrised, registered N-to-log2(N) priority encoder with sticky request capture.
//   Requests are latched into a pending vector and encoded under a selectable priority
//   mode (MSB-first, LSB-first, round-robin). Results are presented on a valid/ready port.
//   Each acknowledged code clears its pending bit. Sits between interrupt/event sources
//   and a single consumer that services one source at a time.
// PARAMETERS
//   N          8   number of request lines; N >= 2, need not be a power of two
//   PRIO_MODE  0   0 = highest index wins, 1 = lowest index wins, 2 = round-robin
//   W          $clog2(N)   localparam, code width (3 for N=8)
// PORTS
//   clk          in   1   single clock, all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   req          in   N   request pulses/levels; bit k high on an edge sets pend[k]
//   mask         in   N   bit k high excludes pend[k] from selection (bit stays pending)
//   code         out  W   encoded index of granted request, registered
//   valid        out  1   code is valid, registered
//   ready        in   1   consumer accepts code when valid && ready on an edge
//   any_pending  out  1   |pend, combinational from pend register
// BEHAVIOUR
//   - Reset (rst=1 on an edge): pend=0, code=0, valid=0, state=IDLE, rr_ptr=N-1.
//     rst overrides everything, including req and any handshake in the same cycle.
//     Reset mid-HOLD drops valid on that edge; the un-acked code is lost.
//   - Pending update on every non-reset edge:
//     pend <= (pend & ~clr) | req.
//     clr is one-hot(code) only when valid && ready, else 0.
//     Set wins: req[k] in the ack cycle of code k leaves pend[k]=1.
//   - Repeat requests on an already-pending bit merge; there is no count or overflow.
//   - elig = pend & ~mask. Selection is combinational from elig. Mode rules:
//     * mode 0: highest set index.
//     * mode 1: lowest set index.
//     * mode 2: first set index searching rr_ptr+1, rr_ptr+2, ... modulo N.
//       rr_ptr <= code on each handshake; rr_ptr is unchanged otherwise.
//   - FSM, two states:
//     * IDLE: valid=0. If elig != 0 on an edge: code <= sel, valid <= 1, go to HOLD.
//       Otherwise stay in IDLE.
//     * HOLD: valid=1. code is frozen; changes to req, mask or pend never alter or retract it.
//       On valid && ready: clear pend[code], valid <= 0, go to IDLE.
//   - Latency: req high at edge e sets pend at e; valid and code appear at edge e+1
//     (2 cycles from req asserted to valid). Any_pending rises 1 cycle after req.
//   - Throughput: at most one grant per 2 cycles; there is always a 1-cycle bubble
//     (valid=0) after each handshake.
//   - Width rules: code is always < N. For non-power-of-two N, unused code values never appear.
//     Round-robin wrap from N-1 goes to 0, not to 2^W-1.
//   - All-masked but pending: stays IDLE, valid=0, any_pending=1.
// TESTING (N=8 unless noted)
//   1 mode0: req=8'hA0 for 1 cycle, ready=1
//     -> valid at +2 cycles, code=7; bubble; code=5; then valid=0, any_pending=0.
//   2 mode1: same stimulus -> code=5 then code=7.
//     mode2 with req=8'h81 held high -> codes 0,7,0,7..., one grant every 2 cycles.
//   3 backpressure: mode0, grant code=3 with ready=0 for 10 cycles; assert req[6] meanwhile
//     -> code stays 3, valid stays 1; after ready, next grant is 6.
//   4 mask: pend={7,3}, mask=8'h80 -> code=3. After ack, mask=0 -> code=7.
//     mask=8'hFF with pend!=0 -> valid stays 0, any_pending=1.
//   5 set-over-clear: req[5]=1 in the ack cycle of code=5 -> pend[5] stays 1; code=5 granted again.
//     rst=1 during HOLD -> next edge valid=0, pend=0, code=0.
//   6 N=5, mode2: req=5'b10001 held -> codes 0,4,0,4; code never exceeds 4.

Source files
------------

// File: rtl/prio_encoder_q.sv
// Registered N-to-log2(N) priority encoder with sticky request capture and a
// valid/ready result port; selection is MSB-first, LSB-first or round-robin.
module prio_encoder_q #(
    parameter int N         = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    output logic [$clog2(N)-1:0] code,
    output logic                 valid,
    input  logic                 ready,
    output logic                 any_pending
);
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state;
    logic [N-1:0] pend;
    logic [N-1:0] elig;
    logic [N-1:0] clr;
    logic [W-1:0] rr_ptr;
    logic [W-1:0] sel_hi;
    logic [W-1:0] sel_lo;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;
    logic         found_lo;
    logic         found_rr;
    int unsigned  idx;

    assign elig        = pend & ~mask;
    assign any_pending = |pend;

    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (elig[i]) begin
                sel_hi = W'(i);
            end
            if (elig[i] && !found_lo) begin
                sel_lo   = W'(i);
                found_lo = 1'b1;
            end
        end
    end

    // Round-robin search starts just past the last granted index and wraps at N,
    // so unused code values of a non-power-of-two N can never be produced.
    always_comb begin
        sel_rr   = '0;
        found_rr = 1'b0;
        idx      = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (elig[idx] && !found_rr) begin
                sel_rr   = W'(idx);
                found_rr = 1'b1;
            end
        end
    end

    always_comb begin
        case (PRIO_MODE)
            0:       sel = sel_hi;
            1:       sel = sel_lo;
            default: sel = sel_rr;
        endcase
    end

    always_comb begin
        clr = '0;
        if (valid && ready) begin
            clr[code] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= '0;
            code   <= '0;
            valid  <= 1'b0;
            state  <= IDLE;
            rr_ptr <= W'(N - 1);
        end else begin
            pend <= (pend & ~clr) | req;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        code  <= sel;
                        valid <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid  <= 1'b0;
                        rr_ptr <= code;
                        state  <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench for prio_encoder_q: MSB/LSB/round-robin modes, backpressure,
// masking, set-over-clear, reset during HOLD and a non-power-of-two width.
module tb_prio_encoder_q;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req8;
    logic [7:0] mask8;
    logic [4:0] req5;
    logic [4:0] mask5;
    logic       ready;

    logic [2:0] code0, code1, code2, code5;
    logic       valid0, valid1, valid2, valid5;
    logic       anyp0, anyp1, anyp2, anyp5;

    int checks   = 0;
    int failures = 0;

    int exp_rr8[4] = '{0, 7, 0, 7};
    int exp_rr5[4] = '{0, 4, 0, 4};

    always #5 clk = ~clk;

    prio_encoder_q #(.N(8), .PRIO_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .req(req8), .mask(mask8), .code(code0),
        .valid(valid0), .ready(ready), .any_pending(anyp0)
    );
    prio_encoder_q #(.N(8), .PRIO_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .req(req8), .mask(mask8), .code(code1),
        .valid(valid1), .ready(ready), .any_pending(anyp1)
    );
    prio_encoder_q #(.N(8), .PRIO_MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .req(req8), .mask(mask8), .code(code2),
        .valid(valid2), .ready(ready), .any_pending(anyp2)
    );
    prio_encoder_q #(.N(5), .PRIO_MODE(2)) u_n5 (
        .clk(clk), .rst(rst), .req(req5), .mask(mask5), .code(code5),
        .valid(valid5), .ready(ready), .any_pending(anyp5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req8  = '0;
        mask8 = '0;
        req5  = '0;
        mask5 = '0;
        ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(valid0), 0);
        check("rst_code", 32'(code0), 0);
        check("rst_anyp", 32'(anyp0), 0);

        // MSB-first vs LSB-first vs round-robin on the same two requests
        req8  = 8'hA0;
        ready = 1'b1;
        tick();
        req8 = '0;
        check("t1_anyp_rise", 32'(anyp0), 1);
        check("t1_no_valid_yet", 32'(valid0), 0);
        tick();
        check("t1_m0_valid", 32'(valid0), 1);
        check("t1_m0_code_a", 32'(code0), 7);
        check("t1_m1_code_a", 32'(code1), 5);
        check("t1_m2_code_a", 32'(code2), 5);
        tick();
        check("t1_bubble", 32'(valid0), 0);
        check("t1_bubble_anyp", 32'(anyp0), 1);
        tick();
        check("t1_m0_valid_b", 32'(valid0), 1);
        check("t1_m0_code_b", 32'(code0), 5);
        check("t1_m1_code_b", 32'(code1), 7);
        check("t1_m2_code_b", 32'(code2), 7);
        tick();
        check("t1_done_valid", 32'(valid0), 0);
        check("t1_done_anyp", 32'(anyp0), 0);
        check("t1_m1_done_anyp", 32'(anyp1), 0);

        // Round-robin with held requests, N=8 and N=5
        do_reset();
        req8  = 8'h81;
        req5  = 5'b10001;
        ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_rr8_valid", 32'(valid2), 1);
            check("t2_rr8_code", 32'(code2), 32'(exp_rr8[k]));
            check("t2_rr5_code", 32'(code5), 32'(exp_rr5[k]));
            check("t2_rr5_range", 32'(code5 < 3'd5), 1);
            tick();
            check("t2_rr8_bubble", 32'(valid2), 0);
            check("t2_rr5_bubble", 32'(valid5), 0);
        end

        // Backpressure: grant is frozen while ready is low
        do_reset();
        req8 = 8'h08;
        tick();
        req8 = '0;
        tick();
        check("t3_code3", 32'(code0), 3);
        req8 = 8'h40;
        tick();
        req8 = '0;
        for (int k = 0; k < 10; k++) begin
            check("t3_hold_code", 32'(code0), 3);
            check("t3_hold_valid", 32'(valid0), 1);
            tick();
        end
        ready = 1'b1;
        tick();
        check("t3_ack_valid", 32'(valid0), 0);
        tick();
        check("t3_next_valid", 32'(valid0), 1);
        check("t3_next_code", 32'(code0), 6);
        tick();
        check("t3_end_anyp", 32'(anyp0), 0);

        // Masking
        do_reset();
        mask8 = 8'h80;
        req8  = 8'h88;
        tick();
        req8 = '0;
        tick();
        check("t4_masked_code", 32'(code0), 3);
        ready = 1'b1;
        tick();
        mask8 = '0;
        check("t4_ack_valid", 32'(valid0), 0);
        tick();
        check("t4_unmask_code", 32'(code0), 7);
        check("t4_unmask_valid", 32'(valid0), 1);
        tick();
        mask8 = 8'hFF;
        req8  = 8'h11;
        tick();
        req8 = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_allmask_valid", 32'(valid0), 0);
            check("t4_allmask_anyp", 32'(anyp0), 1);
        end
        mask8 = '0;
        tick();
        check("t4_release_code", 32'(code0), 4);
        check("t4_release_valid", 32'(valid0), 1);

        // Set wins over clear in the ack cycle
        do_reset();
        req8 = 8'h20;
        tick();
        req8 = '0;
        tick();
        check("t5_code5", 32'(code0), 5);
        ready = 1'b1;
        req8  = 8'h20;
        tick();
        req8 = '0;
        check("t5_ack_valid", 32'(valid0), 0);
        check("t5_ack_anyp", 32'(anyp0), 1);
        tick();
        check("t5_regrant_valid", 32'(valid0), 1);
        check("t5_regrant_code", 32'(code0), 5);
        tick();
        check("t5_cleared_anyp", 32'(anyp0), 0);

        // Reset during HOLD overrides handshake and new requests
        ready = 1'b0;
        req8  = 8'h04;
        tick();
        req8 = '0;
        tick();
        check("t5_hold_code", 32'(code0), 2);
        rst   = 1'b1;
        req8  = 8'h02;
        ready = 1'b1;
        tick();
        rst  = 1'b0;
        req8 = '0;
        check("t5_rst_valid", 32'(valid0), 0);
        check("t5_rst_code", 32'(code0), 0);
        check("t5_rst_anyp", 32'(anyp0), 0);
        tick();
        check("t5_post_rst_valid", 32'(valid0), 0);
        check("t5_post_rst_anyp", 32'(anyp0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
